// File: rtl/fpnew_pkg_snax.sv
// ============================================================================
// Package      : fpnew_pkg_snax
// Description  : Rounding-mode encoding, status struct and helpers shared by
//                the rounding pipeline and its lanes.
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpnew_pkg_snax;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef struct packed {
        logic inexact;
        logic carry;
        logic exact_zero;
    } round_status_t;

    // ROD and DYN exist in the encoding but are not supported by this stage
    function automatic logic is_valid_roundmode(input logic [2:0] mode);
        case (mode)
            RNE, RTZ, RDN, RUP, RMM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpnew_rounding_lane.sv
// ============================================================================
// Module       : fpnew_rounding_lane
// Description  : Combinational single-lane IEEE-754 round-up decision,
//                increment and status flag generation.
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpnew_rounding_lane
    import fpnew_pkg_snax::*;
#(
    parameter int AbsWidth = 16
) (
    input  logic [AbsWidth-1:0] abs_i,
    input  logic                sign_i,
    input  logic [1:0]          rs_i,
    input  logic                eff_sub_i,
    input  roundmode_e          rnd_mode_i,
    output logic [AbsWidth-1:0] abs_o,
    output logic                sign_o,
    output round_status_t       status_o
);

    logic w_round_up;
    logic w_exact_zero;

    // Unsupported encodings fall to the default and behave as truncation
    always_comb begin
        w_round_up = 1'b0;
        case (rnd_mode_i)
            RNE: begin
                case (rs_i)
                    2'b10:   w_round_up = abs_i[0];
                    2'b11:   w_round_up = 1'b1;
                    default: w_round_up = 1'b0;
                endcase
            end
            RDN:     w_round_up = (|rs_i) & sign_i;
            RUP:     w_round_up = (|rs_i) & ~sign_i;
            RMM:     w_round_up = rs_i[1];
            default: w_round_up = 1'b0;
        endcase
    end

    assign w_exact_zero = (abs_i == '0) && (rs_i == 2'b00);

    assign abs_o               = abs_i + AbsWidth'(w_round_up);
    assign status_o.inexact    = |rs_i;
    assign status_o.carry      = w_round_up & (&abs_i);
    assign status_o.exact_zero = w_exact_zero;
    // A cancelled sum is +0 except when rounding toward -inf
    assign sign_o = (w_exact_zero & eff_sub_i) ? (rnd_mode_i == RDN) : sign_i;

endmodule

`default_nettype wire

// File: rtl/fpnew_rounding_pipe.sv
// ============================================================================
// Module       : fpnew_rounding_pipe
// Description  : Multi-lane rounding stage with an elastic valid/ready
//                pipeline, tag passthrough and flush.
//                Optional per-lane mask: FPNEW_ROUNDING_LANE_MASK_EN.
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpnew_rounding_pipe
    import fpnew_pkg_snax::*;
#(
    parameter int NumLanes    = 4,
    parameter int AbsWidth    = 16,
    parameter int NumPipeRegs = 1,
    parameter int TagWidth    = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [2:0]                   rnd_mode_i,
    input  logic [NumLanes-1:0]          eff_sub_i,
    input  logic [NumLanes*AbsWidth-1:0] abs_value_i,
    input  logic [NumLanes-1:0]          sign_i,
    input  logic [NumLanes*2-1:0]        rs_bits_i,
    input  logic [TagWidth-1:0]          tag_i,
`ifdef FPNEW_ROUNDING_LANE_MASK_EN
    input  logic [NumLanes-1:0]          lane_mask_i,
`endif
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [NumLanes*AbsWidth-1:0] abs_rounded_o,
    output logic [NumLanes-1:0]          sign_o,
    output logic [NumLanes-1:0]          exact_zero_o,
    output logic [NumLanes-1:0]          inexact_o,
    output logic [NumLanes-1:0]          carry_o,
    output logic                         mode_err_o,
    output logic [TagWidth-1:0]          tag_o,
    output logic                         busy_o
);

    localparam int LW = NumLanes * AbsWidth;
    localparam int PW = LW + 4 * NumLanes + 1 + TagWidth;

    logic [NumLanes-1:0] w_lane_en;
    logic [LW-1:0]       w_abs;
    logic [NumLanes-1:0] w_sign;
    logic [NumLanes-1:0] w_inexact;
    logic [NumLanes-1:0] w_carry;
    logic [NumLanes-1:0] w_zero;
    logic                w_mode_err;
    logic [PW-1:0]       w_payload;
    logic [PW-1:0]       w_out_payload;

`ifdef FPNEW_ROUNDING_LANE_MASK_EN
    assign w_lane_en = lane_mask_i;
`else
    assign w_lane_en = '1;
`endif

    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        logic [AbsWidth-1:0] w_abs_l;
        logic                w_sign_l;
        round_status_t       w_status_l;

        fpnew_rounding_lane #(
            .AbsWidth (AbsWidth)
        ) u_lane (
            .abs_i      (abs_value_i[l*AbsWidth +: AbsWidth]),
            .sign_i     (sign_i[l]),
            .rs_i       (rs_bits_i[2*l +: 2]),
            .eff_sub_i  (eff_sub_i[l]),
            .rnd_mode_i (roundmode_e'(rnd_mode_i)),
            .abs_o      (w_abs_l),
            .sign_o     (w_sign_l),
            .status_o   (w_status_l)
        );

        assign w_abs[l*AbsWidth +: AbsWidth] = w_lane_en[l] ? w_abs_l : '0;
        assign w_sign[l]    = w_lane_en[l] & w_sign_l;
        assign w_inexact[l] = w_lane_en[l] & w_status_l.inexact;
        assign w_carry[l]   = w_lane_en[l] & w_status_l.carry;
        assign w_zero[l]    = w_lane_en[l] & w_status_l.exact_zero;
    end

    assign w_mode_err = ~is_valid_roundmode(rnd_mode_i);
    assign w_payload  = {w_abs, w_sign, w_inexact, w_carry, w_zero, w_mode_err, tag_i};
    assign {abs_rounded_o, sign_o, inexact_o, carry_o, exact_zero_o, mode_err_o, tag_o} = w_out_payload;

    if (NumPipeRegs == 0) begin : g_comb
        assign w_out_payload = w_payload;
        assign out_valid_o   = in_valid_i & ~flush_i;
        assign in_ready_o    = out_ready_i;
        assign busy_o        = 1'b0;
    end else begin : g_pipe
        logic [NumPipeRegs-1:0] r_valid;
        logic [PW-1:0]          r_data [NumPipeRegs];
        logic [NumPipeRegs-1:0] w_ready;
        logic [NumPipeRegs:0]   w_vin;
        logic [PW-1:0]          w_din  [NumPipeRegs+1];

        assign w_vin    = {r_valid, in_valid_i};
        assign w_din[0] = w_payload;
        for (genvar k = 0; k < NumPipeRegs; k++) begin : g_link
            assign w_din[k+1] = r_data[k];
        end

        // A stage can load when any stage from it to the output has a hole
        always_comb begin
            w_ready = '0;
            for (int k = 0; k < NumPipeRegs; k++) begin
                w_ready[k] = out_ready_i;
                for (int j = k; j < NumPipeRegs; j++) begin
                    if (!r_valid[j]) w_ready[k] = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_valid <= '0;
                for (int k = 0; k < NumPipeRegs; k++) r_data[k] <= '0;
            end else begin
                for (int k = 0; k < NumPipeRegs; k++) begin
                    if (flush_i) begin
                        r_valid[k] <= 1'b0;
                    end else if (w_ready[k]) begin
                        r_valid[k] <= w_vin[k];
                    end
                    if (w_ready[k] && w_vin[k] && !flush_i) begin
                        r_data[k] <= w_din[k];
                    end
                end
            end
        end

        assign in_ready_o    = w_ready[0];
        assign out_valid_o   = r_valid[NumPipeRegs-1];
        assign w_out_payload = w_din[NumPipeRegs];
        assign busy_o        = |r_valid;
    end

endmodule

`default_nettype wire
